// File: rtl/arch_map_table_pkg.sv
// Shared sizing and the per-slot retire packet used by the architectural map table
// and by benches that drive the retire interface.
package sys_defs;

    localparam int ARCHREG_NUMBER = 32;
    localparam int PREG_NUMBER    = 64;
    localparam int ZERO_REG       = 0;
    localparam int ARCH_TAG_W     = $clog2(ARCHREG_NUMBER);
    localparam int PREG_TAG_W     = $clog2(PREG_NUMBER);

    typedef struct packed {
        logic                  en;
        logic                  dest_valid;
        logic [ARCH_TAG_W-1:0] dest_arch;
        logic [PREG_TAG_W-1:0] dest_preg;
        logic                  branch;
        logic                  mispredict;
    } retire_packet_t;

endpackage

// File: rtl/arch_map_table_free_compact.sv
// Told selection for two retiring slots with same-arch forwarding, then lane compaction
// so the freelist always sees freed tags packed from lane 0.
module amt_free_compact #(
    parameter int AW = 5,
    parameter int PW = 6
) (
    input  logic [1:0]         free_i,
    input  logic [1:0][AW-1:0] dest_arch_i,
    input  logic [PW-1:0]      dest_preg0_i,
    input  logic [1:0][PW-1:0] map_told_i,
    output logic [1:0][PW-1:0] retire_tag_o,
    output logic [1:0]         retire_en_o
);

    logic [PW-1:0] told0;
    logic [PW-1:0] told1;

    always_comb begin
        told0 = map_told_i[0];
        // Slot 1 overwriting slot 0's arch frees the preg slot 0 just installed.
        if (free_i[0] && (dest_arch_i[1] == dest_arch_i[0])) begin
            told1 = dest_preg0_i;
        end else begin
            told1 = map_told_i[1];
        end
    end

    always_comb begin
        retire_tag_o = '0;
        retire_en_o  = 2'b00;
        unique case (free_i)
            2'b11: begin
                retire_tag_o[0] = told0;
                retire_tag_o[1] = told1;
                retire_en_o     = 2'b11;
            end
            2'b01: begin
                retire_tag_o[0] = told0;
                retire_en_o     = 2'b01;
            end
            2'b10: begin
                retire_tag_o[0] = told1;
                retire_en_o     = 2'b01;
            end
            default: begin
                retire_tag_o = '0;
                retire_en_o  = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/arch_map_table.sv
// Committed architectural-to-physical map for a 2-wide retire stage; frees Told tags
// to the freelist and broadcasts the committed map on a retiring mispredict.
module arch_map_table #(
    parameter int ARCHREG_NUMBER = sys_defs::ARCHREG_NUMBER,
    parameter int PREG_NUMBER    = sys_defs::PREG_NUMBER
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [1:0]                                   rob_retire_en_i,
    input  logic [1:0]                                   rob_dest_valid_i,
    input  logic [1:0][$clog2(ARCHREG_NUMBER)-1:0]       rob_dest_arch_i,
    input  logic [1:0][$clog2(PREG_NUMBER)-1:0]          rob_dest_preg_i,
    input  logic [1:0]                                   rob_branch_i,
    input  logic [1:0]                                   rob_mispredict_i,
    output logic [1:0][$clog2(PREG_NUMBER)-1:0]          retire_tag_o,
    output logic [1:0]                                   retire_en_o,
    output logic [1:0]                                   retire_branch_o,
    output logic [1:0]                                   branch_recover_o,
    output logic [ARCHREG_NUMBER-1:0][$clog2(PREG_NUMBER)-1:0] map_o,
    output logic                                         recover_valid_o
);

    localparam int AW = $clog2(ARCHREG_NUMBER);
    localparam int PW = $clog2(PREG_NUMBER);

    logic [ARCHREG_NUMBER-1:0][PW-1:0] map_q;
    logic [ARCHREG_NUMBER-1:0][PW-1:0] map_d;
    logic [1:0][PW-1:0]                retire_tag_q;
    logic [1:0][PW-1:0]                retire_tag_d;
    logic [1:0]                        retire_en_q;
    logic [1:0]                        retire_en_d;
    logic [1:0]                        retire_branch_q;
    logic [1:0]                        retire_branch_d;
    logic [1:0]                        branch_recover_q;
    logic [1:0]                        branch_recover_d;
    logic                              recover_valid_q;
    logic                              recover_valid_d;

    logic [1:0]         eff;
    logic [1:0]         mispredict;
    logic [1:0]         free;
    logic [1:0][PW-1:0] map_told;

    always_comb begin
        mispredict = rob_branch_i & rob_mispredict_i;
        eff[0]     = rob_retire_en_i[0];
        // Anything younger than a mispredicted branch is wrong-path and must be dropped.
        eff[1]     = rob_retire_en_i[1] & ~(eff[0] & mispredict[0]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign free[gi] = eff[gi] & rob_dest_valid_i[gi]
                            & (rob_dest_arch_i[gi] != AW'(sys_defs::ZERO_REG));
            assign map_told[gi] = map_q[rob_dest_arch_i[gi]];
        end
    endgenerate

    amt_free_compact #(
        .AW (AW),
        .PW (PW)
    ) u_free_compact (
        .free_i       (free),
        .dest_arch_i  (rob_dest_arch_i),
        .dest_preg0_i (rob_dest_preg_i[0]),
        .map_told_i   (map_told),
        .retire_tag_o (retire_tag_d),
        .retire_en_o  (retire_en_d)
    );

    always_comb begin
        map_d = map_q;
        // Slot 1 is younger, so its write lands last when both target the same arch.
        if (free[0]) begin
            map_d[rob_dest_arch_i[0]] = rob_dest_preg_i[0];
        end
        if (free[1]) begin
            map_d[rob_dest_arch_i[1]] = rob_dest_preg_i[1];
        end
    end

    always_comb begin
        retire_branch_d     = eff & rob_branch_i;
        branch_recover_d    = 2'b00;
        if (eff[0] && mispredict[0]) begin
            branch_recover_d = 2'b01;
        end else if (eff[1] && mispredict[1]) begin
            branch_recover_d = 2'b11;
        end
        recover_valid_d = |branch_recover_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCHREG_NUMBER; i++) begin
                map_q[i] <= PW'(i);
            end
            retire_tag_q     <= '0;
            retire_en_q      <= 2'b00;
            retire_branch_q  <= 2'b00;
            branch_recover_q <= 2'b00;
            recover_valid_q  <= 1'b0;
        end else begin
            map_q            <= map_d;
            retire_tag_q     <= retire_tag_d;
            retire_en_q      <= retire_en_d;
            retire_branch_q  <= retire_branch_d;
            branch_recover_q <= branch_recover_d;
            recover_valid_q  <= recover_valid_d;
        end
    end

    assign map_o            = map_q;
    assign retire_tag_o     = retire_tag_q;
    assign retire_en_o      = retire_en_q;
    assign retire_branch_o  = retire_branch_q;
    assign branch_recover_o = branch_recover_q;
    assign recover_valid_o  = recover_valid_q;

endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table: one retire pair per step, outputs checked 1 ns after the edge.
module tb_arch_map_table;
    import sys_defs::*;

    localparam int AW = ARCH_TAG_W;
    localparam int PW = PREG_TAG_W;

    logic                              clk;
    logic                              reset;
    logic [1:0]                        rob_retire_en_i;
    logic [1:0]                        rob_dest_valid_i;
    logic [1:0][AW-1:0]                rob_dest_arch_i;
    logic [1:0][PW-1:0]                rob_dest_preg_i;
    logic [1:0]                        rob_branch_i;
    logic [1:0]                        rob_mispredict_i;
    logic [1:0][PW-1:0]                retire_tag_o;
    logic [1:0]                        retire_en_o;
    logic [1:0]                        retire_branch_o;
    logic [1:0]                        branch_recover_o;
    logic [ARCHREG_NUMBER-1:0][PW-1:0] map_o;
    logic                              recover_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    arch_map_table dut (
        .clk              (clk),
        .reset            (reset),
        .rob_retire_en_i  (rob_retire_en_i),
        .rob_dest_valid_i (rob_dest_valid_i),
        .rob_dest_arch_i  (rob_dest_arch_i),
        .rob_dest_preg_i  (rob_dest_preg_i),
        .rob_branch_i     (rob_branch_i),
        .rob_mispredict_i (rob_mispredict_i),
        .retire_tag_o     (retire_tag_o),
        .retire_en_o      (retire_en_o),
        .retire_branch_o  (retire_branch_o),
        .branch_recover_o (branch_recover_o),
        .map_o            (map_o),
        .recover_valid_o  (recover_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input retire_packet_t s0, input retire_packet_t s1);
        rob_retire_en_i     = {s1.en, s0.en};
        rob_dest_valid_i    = {s1.dest_valid, s0.dest_valid};
        rob_dest_arch_i[0]  = s0.dest_arch;
        rob_dest_arch_i[1]  = s1.dest_arch;
        rob_dest_preg_i[0]  = s0.dest_preg;
        rob_dest_preg_i[1]  = s1.dest_preg;
        rob_branch_i        = {s1.branch, s0.branch};
        rob_mispredict_i    = {s1.mispredict, s0.mispredict};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic retire_packet_t pkt(input logic en, input logic dv, input int arch,
                                           input int preg, input logic br, input logic mp);
        retire_packet_t p;
        p.en         = en;
        p.dest_valid = dv;
        p.dest_arch  = AW'(arch);
        p.dest_preg  = PW'(preg);
        p.branch     = br;
        p.mispredict = mp;
        return p;
    endfunction

    retire_packet_t idle;

    initial begin
        idle  = pkt(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(idle, idle);
        tick();
        tick();
        reset = 1'b0;
        tick();
        $display("txn reset: map[5]=%0d en=%b", map_o[5], retire_en_o);
        check("rst_map5", 32'(map_o[5]), 32'd5);
        check("rst_map31", 32'(map_o[31]), 32'd31);
        check("rst_en", 32'(retire_en_o), 32'd0);
        check("rst_recover", 32'(recover_valid_o), 32'd0);

        drive(pkt(1'b1, 1'b1, 5, 40, 1'b0, 1'b0), idle);
        tick();
        $display("txn single: tag0=%0d en=%b map[5]=%0d", retire_tag_o[0], retire_en_o, map_o[5]);
        check("single_tag0", 32'(retire_tag_o[0]), 32'd5);
        check("single_en", 32'(retire_en_o), 32'b01);
        check("single_map5", 32'(map_o[5]), 32'd40);

        drive(pkt(1'b1, 1'b1, 3, 33, 1'b0, 1'b0), pkt(1'b1, 1'b1, 3, 34, 1'b0, 1'b0));
        tick();
        $display("txn same_arch: tag={%0d,%0d} en=%b map[3]=%0d",
                 retire_tag_o[1], retire_tag_o[0], retire_en_o, map_o[3]);
        check("same_tag0", 32'(retire_tag_o[0]), 32'd3);
        check("same_tag1", 32'(retire_tag_o[1]), 32'd33);
        check("same_en", 32'(retire_en_o), 32'b11);
        check("same_map3", 32'(map_o[3]), 32'd34);

        drive(pkt(1'b1, 1'b1, 9, 20, 1'b0, 1'b0), pkt(1'b1, 1'b1, 10, 21, 1'b0, 1'b0));
        tick();
        $display("txn dual_diff: tag={%0d,%0d} en=%b", retire_tag_o[1], retire_tag_o[0], retire_en_o);
        check("diff_tag0", 32'(retire_tag_o[0]), 32'd9);
        check("diff_tag1", 32'(retire_tag_o[1]), 32'd10);
        check("diff_map10", 32'(map_o[10]), 32'd21);

        drive(pkt(1'b1, 1'b0, 0, 0, 1'b0, 1'b0), pkt(1'b1, 1'b1, 7, 50, 1'b0, 1'b0));
        tick();
        $display("txn compact: tag0=%0d tag1=%0d en=%b map[7]=%0d",
                 retire_tag_o[0], retire_tag_o[1], retire_en_o, map_o[7]);
        check("cmp_tag0", 32'(retire_tag_o[0]), 32'd7);
        check("cmp_tag1", 32'(retire_tag_o[1]), 32'd0);
        check("cmp_en", 32'(retire_en_o), 32'b01);
        check("cmp_map7", 32'(map_o[7]), 32'd50);

        drive(pkt(1'b1, 1'b0, 0, 0, 1'b1, 1'b1), pkt(1'b1, 1'b1, 4, 45, 1'b0, 1'b0));
        tick();
        $display("txn mispred0: recover=%b en=%b map[4]=%0d rv=%b",
                 branch_recover_o, retire_en_o, map_o[4], recover_valid_o);
        check("mp0_recover", 32'(branch_recover_o), 32'b01);
        check("mp0_branch", 32'(retire_branch_o), 32'b01);
        check("mp0_en", 32'(retire_en_o), 32'b00);
        check("mp0_map4", 32'(map_o[4]), 32'd4);
        check("mp0_rv", 32'(recover_valid_o), 32'd1);
        check("mp0_map7", 32'(map_o[7]), 32'd50);
        drive(idle, idle);
        tick();
        $display("txn idle: rv=%b recover=%b", recover_valid_o, branch_recover_o);
        check("mp0_rv_drop", 32'(recover_valid_o), 32'd0);
        check("mp0_recover_drop", 32'(branch_recover_o), 32'b00);

        drive(pkt(1'b1, 1'b0, 0, 0, 1'b1, 1'b0), pkt(1'b1, 1'b1, 6, 46, 1'b1, 1'b1));
        tick();
        $display("txn mispred1: recover=%b branch=%b en=%b tag0=%0d map[6]=%0d",
                 branch_recover_o, retire_branch_o, retire_en_o, retire_tag_o[0], map_o[6]);
        check("mp1_recover", 32'(branch_recover_o), 32'b11);
        check("mp1_branch", 32'(retire_branch_o), 32'b11);
        check("mp1_en", 32'(retire_en_o), 32'b01);
        check("mp1_tag0", 32'(retire_tag_o[0]), 32'd6);
        check("mp1_map6", 32'(map_o[6]), 32'd46);
        check("mp1_rv", 32'(recover_valid_o), 32'd1);

        drive(pkt(1'b1, 1'b1, 0, 60, 1'b0, 1'b0), idle);
        tick();
        $display("txn zero_reg: en=%b map[0]=%0d", retire_en_o, map_o[0]);
        check("zero_en", 32'(retire_en_o), 32'b00);
        check("zero_map0", 32'(map_o[0]), 32'd0);

        drive(pkt(1'b1, 1'b0, 0, 0, 1'b0, 1'b1), pkt(1'b1, 1'b1, 8, 48, 1'b0, 1'b0));
        tick();
        $display("txn mp_no_branch: recover=%b rv=%b en=%b tag0=%0d",
                 branch_recover_o, recover_valid_o, retire_en_o, retire_tag_o[0]);
        check("mpnb_recover", 32'(branch_recover_o), 32'b00);
        check("mpnb_rv", 32'(recover_valid_o), 32'd0);
        check("mpnb_en", 32'(retire_en_o), 32'b01);
        check("mpnb_tag0", 32'(retire_tag_o[0]), 32'd8);

        reset = 1'b1;
        drive(pkt(1'b1, 1'b1, 5, 41, 1'b1, 1'b1), idle);
        tick();
        $display("txn reset_mid: map[5]=%0d map[3]=%0d en=%b rv=%b",
                 map_o[5], map_o[3], retire_en_o, recover_valid_o);
        check("rmid_map5", 32'(map_o[5]), 32'd5);
        check("rmid_map3", 32'(map_o[3]), 32'd3);
        check("rmid_en", 32'(retire_en_o), 32'b00);
        check("rmid_tag0", 32'(retire_tag_o[0]), 32'd0);
        check("rmid_rv", 32'(recover_valid_o), 32'd0);
        check("rmid_branch", 32'(retire_branch_o), 32'b00);
        reset = 1'b0;
        drive(idle, idle);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
